// File: rtl/alarm_annunciator_pkg.sv
// Shared level codes, state encoding and one-hot bit positions for the alarm annunciator.
package alarm_annunciator_pkg;

    localparam logic [1:0] LVL_OK   = 2'd0;
    localparam logic [1:0] LVL_REG  = 2'd1;
    localparam logic [1:0] LVL_CRIT = 2'd2;

    localparam int IDX_OK   = 0;
    localparam int IDX_REG  = 1;
    localparam int IDX_CRIT = 2;

    typedef enum logic [2:0] {
        S_OK       = 3'd0,
        S_REG      = 3'd1,
        S_CRIT     = 3'd2,
        S_CRIT_ACK = 3'd3,
        S_CRIT_MEM = 3'd4
    } state_t;

    // Non-critical state that matches a committed level (only used when lvl is not CRIT).
    function automatic state_t settle_state(input logic [1:0] lvl);
        return (lvl == LVL_REG) ? S_REG : S_OK;
    endfunction

endpackage

// File: rtl/alarm_annunciator_level_filter.sv
// Decodes the one-hot alarm level and commits it only after it has been stable for PERSIST cycles.
module alarm_annunciator_level_filter
    import alarm_annunciator_pkg::*;
#(
    parameter int PERSIST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alarm_in,
    output logic [1:0] lvl,
    output logic       invalid
);

    localparam int CW = $clog2(PERSIST + 1);

    logic [1:0]    c;
    logic          bad;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n;

    // Map the one-hot input to a level code; anything not exactly one-hot is treated as critical.
    always_comb begin
        c   = LVL_CRIT;
        bad = 1'b0;
        if (alarm_in == (3'b001 << IDX_OK)) begin
            c = LVL_OK;
        end else if (alarm_in == (3'b001 << IDX_REG)) begin
            c = LVL_REG;
        end else if (alarm_in == (3'b001 << IDX_CRIT)) begin
            c = LVL_CRIT;
        end else begin
            bad = 1'b1;
        end
        n = (c == cand) ? cnt + 1'b1 : CW'(1);
    end

    // Persistence counter: any change of candidate restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl     <= LVL_OK;
            cand    <= LVL_OK;
            cnt     <= '0;
            invalid <= 1'b0;
        end else begin
            invalid <= bad;
            if (c == lvl) begin
                cnt <= '0;
            end else begin
                cand <= c;
                if (n == CW'(PERSIST)) begin
                    lvl <= c;
                    cnt <= '0;
                end else begin
                    cnt <= n;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: filtered level drives an LED/buzzer FSM with latched, acknowledgeable critical alarms.
module alarm_annunciator
    import alarm_annunciator_pkg::*;
#(
    parameter int PERSIST    = 4,
    parameter int BLINK_HALF = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alarm_in,
    input  logic       ack,
    output logic       led_ok,
    output logic       led_reg,
    output logic       led_crit,
    output logic       buzzer,
    output logic [1:0] level_out,
    output logic       invalid
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [1:0]    lvl;
    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic          blinking;

    alarm_annunciator_level_filter #(
        .PERSIST (PERSIST)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .alarm_in (alarm_in),
        .lvl      (lvl),
        .invalid  (invalid)
    );

    assign blinking = (state == S_CRIT) || (state == S_CRIT_MEM);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an unacknowledged critical event is remembered after the level drops.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_OK: begin
                if (lvl == LVL_REG)       state_nxt = S_REG;
                else if (lvl == LVL_CRIT) state_nxt = S_CRIT;
            end
            S_REG: begin
                if (lvl == LVL_OK)        state_nxt = S_OK;
                else if (lvl == LVL_CRIT) state_nxt = S_CRIT;
            end
            S_CRIT: begin
                if (lvl == LVL_CRIT) begin
                    if (ack) state_nxt = S_CRIT_ACK;
                end else begin
                    state_nxt = ack ? settle_state(lvl) : S_CRIT_MEM;
                end
            end
            S_CRIT_ACK: begin
                if (lvl != LVL_CRIT) state_nxt = settle_state(lvl);
            end
            S_CRIT_MEM: begin
                if (lvl == LVL_CRIT) state_nxt = S_CRIT;
                else if (ack)        state_nxt = settle_state(lvl);
            end
            default: state_nxt = S_OK;
        endcase
    end

    // Blink phase runs only while the alarm is unacknowledged and keeps its phase across CRIT/MEM moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (!blinking) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Indicator outputs decoded from the current state and blink phase.
    always_comb begin
        led_ok    = (state == S_OK);
        led_reg   = (state == S_REG);
        led_crit  = 1'b0;
        buzzer    = blinking;
        level_out = lvl;
        if (blinking)                 led_crit = blink;
        else if (state == S_CRIT_ACK) led_crit = 1'b1;
    end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Scoreboard bench: stimulus queues expected output vectors per cycle, a monitor compares them at negedge.
module tb_alarm_annunciator;

    logic       clk;
    logic       rst_n;
    logic [2:0] alarm_in;
    logic       ack;
    logic       led_ok;
    logic       led_reg;
    logic       led_crit;
    logic       buzzer;
    logic [1:0] level_out;
    logic       invalid;

    typedef struct {
        int         cyc;
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    alarm_annunciator #(
        .PERSIST    (4),
        .BLINK_HALF (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_in  (alarm_in),
        .ack       (ack),
        .led_ok    (led_ok),
        .led_reg   (led_reg),
        .led_crit  (led_crit),
        .buzzer    (buzzer),
        .level_out (level_out),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: value k means k rising edges have occurred.
    always @(posedge clk) cyc <= cyc + 1;

    // Expected vector layout {led_ok, led_reg, led_crit, buzzer, level_out[1:0], invalid}.
    function automatic logic [6:0] v(input logic ok, input logic rg, input logic cr,
                                     input logic bz, input logic [1:0] lv, input logic inv);
        return {ok, rg, cr, bz, lv, inv};
    endfunction

    task automatic expectAt(input int offset, input string nm, input logic [6:0] e);
        exp_t item;
        item.cyc  = cyc + offset;
        item.exp  = e;
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic k);
        alarm_in = a;
        ack      = k;
    endtask

    task automatic holdCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input exp_t item);
        logic [6:0] obs;
        obs   = {led_ok, led_reg, led_crit, buzzer, level_out, invalid};
        total = total + 1;
        if (obs !== item.exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s cyc=%0d got=%b expected=%b", item.name, cyc, obs, item.exp);
        end
    endtask

    // Monitor: compare every scoreboard entry due this cycle; an overdue entry counts as a failure.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total = total + 1;
                bad   = bad + 1;
                $display("[TB] FAIL %s overdue cyc=%0d got=none expected=%b", sb[i].name, cyc, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        applyStimulus(3'b001, 1'b0);
        holdCycles(2);
        expectAt(0, "in_reset", v(1, 0, 0, 0, 2'd0, 0));
        holdCycles(1);
        rst_n = 1'b1;
        expectAt(0, "reset_release", v(1, 0, 0, 0, 2'd0, 0));
        expectAt(1, "reset_idle", v(1, 0, 0, 0, 2'd0, 0));
        holdCycles(2);

        applyStimulus(3'b010, 1'b0);
        expectAt(3, "reg_edge3", v(1, 0, 0, 0, 2'd0, 0));
        expectAt(4, "reg_lvl_edge4", v(1, 0, 0, 0, 2'd1, 0));
        expectAt(5, "reg_led_edge5", v(0, 1, 0, 0, 2'd1, 0));
        holdCycles(6);

        applyStimulus(3'b001, 1'b0);
        expectAt(3, "glitch3_hold", v(0, 1, 0, 0, 2'd1, 0));
        expectAt(8, "glitch3_after", v(0, 1, 0, 0, 2'd1, 0));
        holdCycles(3);
        applyStimulus(3'b010, 1'b0);
        holdCycles(6);

        applyStimulus(3'b001, 1'b0);
        expectAt(3, "ok_edge3", v(0, 1, 0, 0, 2'd1, 0));
        expectAt(4, "ok_lvl_edge4", v(0, 1, 0, 0, 2'd0, 0));
        expectAt(5, "ok_led_edge5", v(1, 0, 0, 0, 2'd0, 0));
        holdCycles(6);

        applyStimulus(3'b100, 1'b0);
        expectAt(4, "crit_lvl_edge4", v(1, 0, 0, 0, 2'd2, 0));
        expectAt(5, "crit_enter", v(0, 0, 1, 1, 2'd2, 0));
        expectAt(12, "blink_on_last", v(0, 0, 1, 1, 2'd2, 0));
        expectAt(13, "blink_off_first", v(0, 0, 0, 1, 2'd2, 0));
        expectAt(20, "blink_off_last", v(0, 0, 0, 1, 2'd2, 0));
        expectAt(21, "blink_on_again", v(0, 0, 1, 1, 2'd2, 0));
        holdCycles(22);

        applyStimulus(3'b100, 1'b1);
        expectAt(1, "crit_acked", v(0, 0, 1, 0, 2'd2, 0));
        holdCycles(1);
        applyStimulus(3'b100, 1'b0);
        expectAt(2, "acked_steady", v(0, 0, 1, 0, 2'd2, 0));
        holdCycles(2);
        applyStimulus(3'b001, 1'b0);
        expectAt(4, "acked_lvl_ok", v(0, 0, 1, 0, 2'd0, 0));
        expectAt(5, "acked_to_ok", v(1, 0, 0, 0, 2'd0, 0));
        holdCycles(6);

        applyStimulus(3'b100, 1'b0);
        expectAt(5, "crit2_enter", v(0, 0, 1, 1, 2'd2, 0));
        holdCycles(7);
        applyStimulus(3'b010, 1'b0);
        expectAt(4, "mem_lvl_reg", v(0, 0, 1, 1, 2'd1, 0));
        expectAt(5, "mem_enter", v(0, 0, 1, 1, 2'd1, 0));
        expectAt(6, "mem_blink_cont", v(0, 0, 0, 1, 2'd1, 0));
        holdCycles(7);
        applyStimulus(3'b010, 1'b1);
        expectAt(1, "mem_ack_reg", v(0, 1, 0, 0, 2'd1, 0));
        holdCycles(1);
        applyStimulus(3'b010, 1'b0);
        holdCycles(2);

        applyStimulus(3'b011, 1'b0);
        expectAt(1, "multihot_inv", v(0, 1, 0, 0, 2'd1, 1));
        expectAt(4, "multihot_lvl", v(0, 1, 0, 0, 2'd2, 1));
        expectAt(5, "multihot_crit", v(0, 0, 1, 1, 2'd2, 1));
        holdCycles(5);
        applyStimulus(3'b000, 1'b0);
        expectAt(1, "zero_inv", v(0, 0, 1, 1, 2'd2, 1));
        holdCycles(2);
        applyStimulus(3'b100, 1'b0);
        expectAt(1, "valid_again", v(0, 0, 1, 1, 2'd2, 0));
        holdCycles(8);

        expectAt(0, "pre_reset_crit", v(0, 0, 0, 1, 2'd2, 0));
        holdCycles(1);
        rst_n = 1'b0;
        expectAt(0, "async_reset", v(1, 0, 0, 0, 2'd0, 0));
        holdCycles(2);
        applyStimulus(3'b001, 1'b1);
        rst_n = 1'b1;
        holdCycles(2);
        applyStimulus(3'b100, 1'b1);
        expectAt(5, "ack_held_crit", v(0, 0, 1, 1, 2'd2, 0));
        expectAt(6, "ack_held_acked", v(0, 0, 1, 0, 2'd2, 0));
        holdCycles(8);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            holdCycles(1);
            guard++;
        end
        if (sb.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
